// File: rtl/img_stream_axi_burst_writer.sv
// Buffers an AXI4-Stream of 32-bit pixel words and writes one frame to memory with AXI4 INCR
// bursts. Define IMG_TLAST_CHECK_EN to flag a misplaced or missing S_AXIS_TLAST on ERROR.
module img_stream_axi_burst_writer #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_BURST_LEN  = 8,
    parameter int unsigned C_FIFO_DEPTH       = 16,
    parameter int unsigned C_FRAME_WORDS_W    = 24
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          INIT_AXI_TXN,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [C_FRAME_WORDS_W-1:0]    FRAME_WORDS,
    output logic                          TXN_DONE,
    output logic                          ERROR,
    output logic                          BUSY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    output logic                          S_AXIS_TREADY,
    input  logic                          S_AXIS_TLAST,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int unsigned AW  = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW  = C_M_AXI_DATA_WIDTH;
    localparam int unsigned FW  = C_FRAME_WORDS_W;
    localparam int unsigned PW  = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned BLW = $clog2(C_M_AXI_BURST_LEN) + 1;

    typedef enum logic [2:0] {StIdle, StFill, StAddr, StData, StResp, StDone} state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [FW-1:0]    remaining_q, remaining_d;
    logic [FW-1:0]    taken_q, taken_d;
    logic [BLW-1:0]   blen_q, blen_d;
    logic [BLW-1:0]   beat_q, beat_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    fifo_mem [C_FIFO_DEPTH];

    logic             fifo_full, fifo_empty, push, pop;
    logic [BLW-1:0]   blen_cur;

    assign fifo_full  = (count_q == CW'(C_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Stream intake stops once the whole frame has been taken, not just when the FIFO fills.
    assign S_AXIS_TREADY = busy_q && !fifo_full && (taken_q != frame_q);
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;

    assign M_AXI_AWVALID = (state_q == StAddr);
    assign M_AXI_AWADDR  = M_AXI_AWVALID ? addr_q : '0;
    assign M_AXI_AWLEN   = M_AXI_AWVALID ? 8'(blen_q - BLW'(1)) : '0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = (state_q == StData) && !fifo_empty;
    assign M_AXI_WDATA   = M_AXI_WVALID ? fifo_mem[rd_ptr_q] : '0;
    assign M_AXI_WLAST   = M_AXI_WVALID && (beat_q == blen_q - BLW'(1));
    assign M_AXI_BREADY  = (state_q == StResp);
    assign pop           = M_AXI_WVALID && M_AXI_WREADY;

    assign TXN_DONE = done_q;
    assign BUSY     = busy_q;
    assign ERROR    = error_q;

    assign blen_cur = (remaining_q >= FW'(C_M_AXI_BURST_LEN)) ? BLW'(C_M_AXI_BURST_LEN)
                                                              : BLW'(remaining_q);

`ifndef IMG_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = S_AXIS_TLAST;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        addr_d      = addr_q;
        frame_d     = frame_q;
        remaining_d = remaining_q;
        taken_d     = taken_q;
        blen_d      = blen_q;
        beat_d      = beat_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            taken_d  = taken_q + FW'(1);
`ifdef IMG_TLAST_CHECK_EN
            if (S_AXIS_TLAST != (taken_q == frame_q - FW'(1))) begin
                error_d = 1'b1;
            end
`endif
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (INIT_AXI_TXN) begin
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    addr_d      = BASE_ADDR;
                    frame_d     = FRAME_WORDS;
                    remaining_d = FRAME_WORDS;
                    taken_d     = '0;
                    state_d     = (FRAME_WORDS == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if (32'(count_q) >= 32'(blen_cur)) begin
                    blen_d  = blen_cur;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (M_AXI_AWREADY) begin
                    remaining_d = remaining_q - FW'(blen_q);
                    beat_d      = '0;
                    state_d     = StData;
                end
            end
            StData: begin
                if (pop) begin
                    beat_d = beat_q + BLW'(1);
                    if (M_AXI_WLAST) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        error_d = 1'b1;
                    end
                    addr_d  = addr_q + (AW'(blen_q) << 2);
                    state_d = (remaining_q == '0) ? StDone : StFill;
                end
            end
            StDone: begin
                // TXN_DONE and the BUSY drop both register on this edge.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= '0;
            frame_q     <= '0;
            remaining_q <= '0;
            taken_q     <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            addr_q      <= addr_d;
            frame_q     <= frame_d;
            remaining_q <= remaining_d;
            taken_q     <= taken_d;
            blen_q      <= blen_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= S_AXIS_TDATA;
        end
    end

endmodule

// File: tb/tb_img_stream_axi_burst_writer.sv
// Bench for img_stream_axi_burst_writer: table of frames driven through a stalling AXI slave
// model, plus hand-written zero-length, busy-INIT and mid-burst reset sequences.
module tb_img_stream_axi_burst_writer;

    localparam int BURST = 8;
`ifdef IMG_TLAST_CHECK_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif
    localparam logic [127:0] RESET_OUTS =
        128'({4'b0000, 32'h0, 8'h00, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF, 3'b000});

    logic        clk = 1'b0;
    logic        ARESET = 1'b1;
    logic        INIT_AXI_TXN = 1'b0;
    logic [31:0] BASE_ADDR = '0;
    logic [23:0] FRAME_WORDS = '0;
    logic        TXN_DONE, ERROR, BUSY;
    logic [31:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST = 1'b0;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    img_stream_axi_burst_writer dut (
        .ACLK          (clk),
        .ARESET        (ARESET),
        .INIT_AXI_TXN  (INIT_AXI_TXN),
        .BASE_ADDR     (BASE_ADDR),
        .FRAME_WORDS   (FRAME_WORDS),
        .TXN_DONE      (TXN_DONE),
        .ERROR         (ERROR),
        .BUSY          (BUSY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    typedef struct {
        logic [31:0] base;
        int          words;
        int          tlast_pos;
        int          err_burst;
        bit          stall;
        int          exp_bursts;
        bit          exp_error;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int row, input int i);
        return {16'(row), 16'(i + 1)};
    endfunction

    function automatic logic [127:0] outs();
        return 128'({TXN_DONE, ERROR, BUSY, S_AXIS_TREADY, M_AXI_AWADDR, M_AXI_AWLEN,
                     M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB,
                     M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY});
    endfunction

    task automatic idle_inputs();
        INIT_AXI_TXN  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
    endtask

    // One frame against a slave model; memory image and burst list come from frame arithmetic.
    task automatic run_frame(input vec_t v, input int row);
        int sent = 0, beats = 0, aw_cnt = 0, b_cnt = 0, done_cnt = 0, after_done = 0;
        int beat = 0, cur_len = 0, b_delay = 0, exp_len;
        logic [31:0] cur_addr = '0, exp_addr, hold_awaddr = '0, hold_wdata = '0;
        logic [7:0]  hold_awlen = '0;
        logic        hold_wlast = 1'b0;
        bit          aw_open = 0, pend_b = 0, aw_hold = 0, w_hold = 0;
        logic [31:0] mem [int unsigned];

        @(negedge clk);
        INIT_AXI_TXN = 1'b1;
        BASE_ADDR    = v.base;
        FRAME_WORDS  = 24'(v.words);
        for (int cyc = 0; cyc < 3000 && after_done < 3; cyc++) begin
            @(negedge clk);
            // A second INIT while busy must be ignored.
            INIT_AXI_TXN = (cyc == 5);
            if (cyc == 0) begin
                BASE_ADDR   = 32'hdead_0000;
                FRAME_WORDS = 24'd3;
                check("init_busy", 128'(BUSY), 128'(1));
                check("init_error_clear", 128'(ERROR), 128'(0));
            end
            M_AXI_AWREADY = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            M_AXI_WREADY  = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            S_AXIS_TVALID = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            S_AXIS_TDATA  = word_of(row, sent);
            S_AXIS_TLAST  = (sent == v.tlast_pos);
            if (pend_b && b_delay > 0) b_delay--;
            M_AXI_BVALID = pend_b && (b_delay == 0);
            M_AXI_BRESP  = (M_AXI_BVALID && b_cnt == v.err_burst) ? 2'b10 : 2'b00;

            if (aw_hold)
                check("aw_stable", 128'({M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN}),
                      128'({1'b1, hold_awaddr, hold_awlen}));
            if (w_hold)
                check("w_stable", 128'({M_AXI_WVALID, M_AXI_WDATA, M_AXI_WLAST}),
                      128'({1'b1, hold_wdata, hold_wlast}));
            aw_hold     = M_AXI_AWVALID && !M_AXI_AWREADY;
            hold_awaddr = M_AXI_AWADDR;
            hold_awlen  = M_AXI_AWLEN;
            w_hold      = M_AXI_WVALID && !M_AXI_WREADY;
            hold_wdata  = M_AXI_WDATA;
            hold_wlast  = M_AXI_WLAST;

            if (M_AXI_WVALID && M_AXI_WREADY) begin
                check("w_after_aw", 128'(aw_open), 128'(1));
                mem[cur_addr + 32'(beat * 4)] = M_AXI_WDATA;
                check("wlast", 128'(M_AXI_WLAST), 128'(beat == cur_len));
                beat++;
                beats++;
                if (M_AXI_WLAST) begin
                    aw_open = 0;
                    pend_b  = 1;
                    b_delay = v.stall ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                exp_len  = (v.words - aw_cnt * BURST < BURST) ? v.words - aw_cnt * BURST : BURST;
                exp_addr = v.base + 32'(aw_cnt * BURST * 4);
                check("aw_one_outstanding", 128'({aw_open, pend_b}), 128'(0));
                check("awaddr", 128'(M_AXI_AWADDR), 128'(exp_addr));
                check("awlen", 128'(M_AXI_AWLEN), 128'(exp_len - 1));
                cur_addr = exp_addr;
                cur_len  = exp_len - 1;
                beat     = 0;
                aw_cnt++;
                aw_open  = 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                pend_b = 0;
                b_cnt++;
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) sent++;
            if (done_cnt > 0) after_done++;
            if (TXN_DONE) begin
                done_cnt++;
                check("busy_at_done", 128'(BUSY), 128'(0));
                check("error_at_done", 128'(ERROR), 128'(v.exp_error));
                check("bresp_count_at_done", 128'(b_cnt), 128'(v.exp_bursts));
            end
        end
        idle_inputs();
        check("done_once", 128'(done_cnt), 128'(1));
        check("aw_count", 128'(aw_cnt), 128'(v.exp_bursts));
        check("accepted_words", 128'(sent), 128'(v.words));
        check("w_beats", 128'(beats), 128'(v.words));
        for (int i = 0; i < v.words; i++) begin
            exp_addr = v.base + 32'(i * 4);
            check("mem_data", mem.exists(exp_addr) ? 128'(mem[exp_addr]) : 128'hx,
                  128'(word_of(row, i)));
        end
    endtask

    initial begin
        bit aw_seen;
        bit seen;

        vecs[0] = '{32'h0000_1000, 8,  7,  -1, 1'b0, 1, 1'b0};
        vecs[1] = '{32'h0000_1000, 20, 19, -1, 1'b0, 3, 1'b0};
        vecs[2] = '{32'h0000_2000, 64, 63, -1, 1'b1, 8, 1'b0};
        vecs[3] = '{32'h0000_3000, 20, 19, 1,  1'b0, 3, 1'b1};
        vecs[4] = '{32'h0000_4000, 8,  4,  -1, 1'b0, 1, TLAST_EN};
        vecs[5] = '{32'h0000_8000, 37, 36, 4,  1'b1, 5, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), RESET_OUTS);
        ARESET = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs(), RESET_OUTS);

        for (int r = 0; r < 6; r++) run_frame(vecs[r], r);

        // Zero-length frame: TXN_DONE two cycles after INIT, no AXI traffic, ERROR cleared.
        aw_seen = 0;
        @(negedge clk);
        INIT_AXI_TXN = 1'b1;
        BASE_ADDR    = 32'h0000_5000;
        FRAME_WORDS  = 24'd0;
        @(negedge clk);
        INIT_AXI_TXN = 1'b0;
        aw_seen |= M_AXI_AWVALID;
        check("f0_no_done_yet", 128'(TXN_DONE), 128'(0));
        check("f0_busy", 128'(BUSY), 128'(1));
        check("f0_error_clear", 128'(ERROR), 128'(0));
        @(negedge clk);
        aw_seen |= M_AXI_AWVALID;
        check("f0_done", 128'(TXN_DONE), 128'(1));
        check("f0_busy_drop", 128'(BUSY), 128'(0));
        @(negedge clk);
        aw_seen |= M_AXI_AWVALID;
        check("f0_done_pulse", 128'(TXN_DONE), 128'(0));
        check("f0_no_aw", 128'(aw_seen), 128'(0));

        // Reset while a burst is in its data phase.
        @(negedge clk);
        INIT_AXI_TXN  = 1'b1;
        BASE_ADDR     = 32'h0000_6000;
        FRAME_WORDS   = 24'd16;
        S_AXIS_TVALID = 1'b1;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            INIT_AXI_TXN = 1'b0;
            S_AXIS_TDATA = 32'(c);
            seen = M_AXI_WVALID;
        end
        check("reach_data_phase", 128'(seen), 128'(1));
        ARESET = 1'b1;
        @(negedge clk);
        check("mid_data_reset_outputs", outs(), RESET_OUTS);
        idle_inputs();
        ARESET = 1'b0;
        @(negedge clk);

        run_frame(vecs[0], 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
